// File: rtl/gf_div_pkg.sv
// ============================================================================
// Module      : gf_div_pkg
// Description : Shared types and field constants for the GF(2^8) divider.
//               Field polynomial x^8+x^4+x^3+x^2+1 (0x11D).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gf_div_pkg;

  localparam int         IO_WIDTH = 8;
  // Low byte of the reduction polynomial; the x^8 term is implicit.
  localparam logic [7:0] PP_CHAR  = 8'd29;
  localparam int         N_ITER   = IO_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/gf_mul8_comb.sv
// ============================================================================
// Module      : gf_mul8_comb
// Description : Purely combinational GF(2^8) multiplier. Carry-less 8x8
//               product into 15 bits, then MSB-first polynomial reduction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf_mul8_comb #(
  parameter logic [7:0] PP_CHAR = 8'd29
) (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_p
);

  logic [14:0] w_prod;

  // Carry-less product, then fold bits 14..8 back with the full 9-bit
  // polynomial so each reduced bit is cleared as it is folded.
  always_comb begin
    w_prod = '0;
    for (int i = 0; i < 8; i++) begin
      if (i_b[i]) begin
        w_prod = w_prod ^ ({7'b0, i_a} << i);
      end
    end
    for (int k = 14; k >= 8; k--) begin
      if (w_prod[k]) begin
        w_prod = w_prod ^ ({6'b0, 1'b1, PP_CHAR} << (k - 8));
      end
    end
  end

  assign o_p = w_prod[7:0];

endmodule

`default_nettype wire

// File: rtl/gf_div.sv
// ============================================================================
// Module      : gf_div
// Description : Multi-cycle GF(2^8) inverter/divider. Computes b^-1 = b^254
//               by 7 square-and-multiply iterations, then optionally a*b^-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf_div
  import gf_div_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       trigger_i,
  input  logic [7:0] op_a_i,
  input  logic [7:0] op_b_i,
  input  logic       op_select_i,
  output logic [7:0] result_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam logic [2:0] CNT_LAST = 3'(N_ITER - 1);

  div_state_e r_state;
  div_state_e w_state_nxt;

  logic [7:0] r_a;
  logic       r_sel;
  logic [7:0] r_p;
  logic [7:0] r_r;
  logic [2:0] r_cnt;
  logic [7:0] r_result;
  logic       r_err;

  logic [7:0] w_sq;
  logic [7:0] w_acc;
  logic [7:0] w_fin;

  // p^2, r*p^2 chained in one cycle, and the final a*r product.
  gf_mul8_comb #(.PP_CHAR(PP_CHAR)) u_mul_sq  (.i_a(r_p), .i_b(r_p),  .o_p(w_sq));
  gf_mul8_comb #(.PP_CHAR(PP_CHAR)) u_mul_acc (.i_a(r_r), .i_b(w_sq), .o_p(w_acc));
  gf_mul8_comb #(.PP_CHAR(PP_CHAR)) u_mul_fin (.i_a(r_a), .i_b(r_r),  .o_p(w_fin));

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a zero divisor skips straight to DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (trigger_i) w_state_nxt = (op_b_i == 8'h00) ? DONE : CALC;
      CALC:    if (r_cnt == CNT_LAST) w_state_nxt = FINAL;
      FINAL:   w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration registers, result and error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a      <= '0;
      r_sel    <= 1'b0;
      r_p      <= '0;
      r_r      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (trigger_i) begin
            r_a   <= op_a_i;
            r_sel <= op_select_i;
            if (op_b_i == 8'h00) begin
              r_result <= 8'h00;
              r_err    <= 1'b1;
            end else begin
              // p starts at b itself; the divisor is not needed after this.
              r_p   <= op_b_i;
              r_r   <= 8'h01;
              r_cnt <= '0;
              r_err <= 1'b0;
            end
          end
        end
        CALC: begin
          r_p   <= w_sq;
          r_r   <= w_acc;
          r_cnt <= r_cnt + 3'd1;
        end
        FINAL: begin
          r_result <= r_sel ? w_fin : r_r;
        end
        DONE: begin
          r_result <= r_result;
        end
        default: begin
          r_result <= 8'h00;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign err_o    = r_err;
  assign busy_o   = (r_state != IDLE);
  assign done_o   = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_gf_div.sv
// ============================================================================
// Module      : tb_gf_div
// Description : Self-checking bench for gf_div: directed vector table plus
//               reset, operand-stability and back-to-back sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf_div;

  logic       clk = 1'b0;
  logic       rst;
  logic       trigger;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       sel;
  logic [7:0] result;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {
    logic       sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       err;
  } vec_t;

  vec_t vecs[9];

  gf_div dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .trigger_i  (trigger),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .op_select_i(sel),
    .result_o   (result),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // xtime-based reference multiply (shift a, conditionally fold 0x1D).
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    logic       c;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      c  = aa[7];
      aa = {aa[6:0], 1'b0};
      if (c) aa = aa ^ 8'h1D;
    end
    return acc;
  endfunction

  // Start one operation and wait for done; lat = edges after accept edge,
  // bcnt = cycles with busy high up to and including the done cycle.
  task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input bit scramble, output int lat, output int bcnt);
    @(negedge clk);
    op_a = a; op_b = b; sel = s; trigger = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trigger = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 30) begin
      if (busy) bcnt++;
      if (scramble) begin
        op_a    = 8'($urandom);
        op_b    = 8'($urandom);
        sel     = 1'($urandom);
        trigger = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    if (busy) bcnt++;
    trigger = 1'b0;
  endtask

  task automatic do_vec(input vec_t v, input bit scramble, input string tag);
    int lat, bcnt;
    logic [7:0] held;
    run_op(v.sel, v.a, v.b, scramble, lat, bcnt);
    check({tag, " latency"}, lat, (v.b == 8'h00) ? 0 : 8);
    check({tag, " busy cycles"}, bcnt, (v.b == 8'h00) ? 1 : 9);
    check({tag, " result"}, result, v.res);
    check({tag, " err"}, err, v.err);
    held = result;
    @(negedge clk);
    check({tag, " done one cycle"}, {busy, done}, 2'b00);
    repeat (2) @(negedge clk);
    check({tag, " result held in idle"}, {err, result}, {v.err, held});
  endtask

  initial begin
    int t;
    int prev;
    bit seen;

    vecs[0] = '{sel: 1'b0, a: 8'h00, b: 8'h02, res: 8'h8E, err: 1'b0};
    vecs[1] = '{sel: 1'b0, a: 8'h00, b: 8'h03, res: 8'hF4, err: 1'b0};
    vecs[2] = '{sel: 1'b0, a: 8'h00, b: 8'h01, res: 8'h01, err: 1'b0};
    vecs[3] = '{sel: 1'b1, a: 8'h06, b: 8'h03, res: 8'h02, err: 1'b0};
    vecs[4] = '{sel: 1'b1, a: 8'h01, b: 8'h02, res: 8'h8E, err: 1'b0};
    vecs[5] = '{sel: 1'b1, a: 8'h00, b: 8'h57, res: 8'h00, err: 1'b0};
    vecs[6] = '{sel: 1'b1, a: 8'h12, b: 8'h00, res: 8'h00, err: 1'b1};
    vecs[7] = '{sel: 1'b1, a: 8'h8E, b: 8'h8E, res: 8'h01, err: 1'b0};
    vecs[8] = '{sel: 1'b0, a: 8'h55, b: 8'h00, res: 8'h00, err: 1'b1};

    rst = 1'b1; trigger = 1'b0; op_a = 8'h00; op_b = 8'h00; sel = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", {result, busy, done, err}, 11'h000);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Operands and trigger wiggle every cycle after the accept edge.
    do_vec(vecs[3], 1'b1, "stable div");
    do_vec(vecs[1], 1'b1, "stable inv");

    // Reset in the middle of CALC: outputs clear at once, no done follows.
    @(negedge clk);
    op_b = 8'h03; sel = 1'b0; trigger = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trigger = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("reset mid-CALC outputs", {result, busy, done, err}, 11'h000);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("no activity after abort", seen, 1'b0);

    // Trigger held high: every nonzero b, one operation every 10 cycles.
    @(negedge clk);
    op_b = 8'h01; sel = 1'b0; trigger = 1'b1;
    prev = 0;
    for (int b = 1; b < 256; b++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!done && t < 30);
      if (t >= 30) begin
        check($sformatf("b2b timeout b=%0d", b), 0, 1);
        break;
      end
      check($sformatf("inverse b=0x%02h", b), ref_mul(result, 8'(b)), 8'h01);
      check($sformatf("inverse err b=0x%02h", b), err, 1'b0);
      if (b > 1) check($sformatf("b2b spacing b=%0d", b), cyc - prev, 10);
      prev = cyc;
      op_b = 8'(b + 1);
    end
    trigger = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gf_div.md
Name: gf_div

Overview:
- Multi-cycle GF(2^8) inverter/divider. It is the inverse-direction companion of the team's GF(2^8) multiplier/adder IP and uses the same field: reduction polynomial x^8+x^4+x^3+x^2+1 (0x11D, low byte 29).
- Computes b^-1 = b^254 by iterated square-and-multiply, then optionally multiplies by a to give a/b.
- Sits beside the multiplier on the same peripheral side and uses the same trigger/status style.

Parameters:
- IO_WIDTH, 8, operand/result width; fixed, not overridable.
- PP_CHAR, 29, low byte of the reduction polynomial; the x^8 term is implicit.
- N_ITER, 7, square-and-multiply iterations; equals IO_WIDTH-1.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- trigger_i  in  1  start request; sampled only in IDLE
- op_a_i  in  8  dividend; used when op_select_i=1
- op_b_i  in  8  divisor / value to invert
- op_select_i  in  1  0: result=inv(b); 1: result=a/b
- result_o  out  8  result; held until the next accepted trigger
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse, high only in DONE
- err_o  out  1  divide-by-zero flag; held with result_o

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; result_o=0x00, busy_o=0, done_o=0, err_o=0.
  - All internal registers (a_q, b_q, sel_q, p, r, cnt) cleared.
  - Reset during any state aborts the operation; no done_o pulse follows.
- IDLE:
  - On a clock edge with trigger_i=1, latch a_q=op_a_i, b_q=op_b_i, sel_q=op_select_i.
  - Operand ports are not sampled after this edge.
  - If op_b_i==0: result<=0x00, err<=1, next state DONE (latency 1).
  - Else: p<=op_b_i, r<=0x01, cnt<=0, err<=0, next state CALC.
- CALC, one iteration per cycle:
  - sq=p*p; p<=sq; r<=r*sq (two chained combinational GF multiplies).
  - cnt<=cnt+1. When cnt==N_ITER-1, next state FINAL.
  - After 7 iterations r = b^(2+4+...+128) = b^254.
- FINAL: result<= sel_q ? a_q*r : r. Next state DONE.
- DONE: done_o=1 for exactly one cycle. Next state IDLE unconditionally; trigger_i is ignored here.
- Latency, counting the accept edge as T0:
  - Nonzero b: result_o updates and done_o rises after edge T8 (7 CALC edges T1..T7, FINAL edge T8). busy_o is high for 9 cycles.
  - b==0: done_o high in the cycle after T0.
- Multiply arithmetic:
  - Carry-less 8x8 product into a 15-bit intermediate.
  - Reduce bits 14..8, MSB first, each by XOR of (PP_CHAR << (k-8)).
  - Bit widths are exact; no truncation before reduction.
- Boundary conditions:
  - b=0x01 gives 0x01.
  - a=0 with sel=1 gives 0x00 and err_o=0.
  - A trigger held high continuously restarts in the cycle after DONE, giving back-to-back operations with one IDLE cycle between them.
  - result_o/err_o are not cleared by returning to IDLE; they change only on the next accept or on reset.
- Unknown state encoding: go to IDLE, result 0x00.

Decomposition:
- Package gf_div_pkg holds:
  - typedef enum div_state_e {IDLE, CALC, FINAL, DONE}
  - PP_CHAR, N_ITER, IO_WIDTH constants
- Sub-module gf_mul8_comb: purely combinational GF(2^8) multiply (8-bit a, b in; 8-bit product out), parameterised by PP_CHAR.
  - Instantiated three times: square, accumulate, final.
  - Reusable by the multiplier IP.

Test Plan:
- Reset mid-CALC: trigger b=0x03, assert rst_i at T4 -> all outputs 0 immediately; state IDLE; no done_o.
- Inverse: sel=0, b=0x02 -> done_o after T8, result_o=0x8E, err_o=0; b=0x03 -> 0xF4; b=0x01 -> 0x01.
- Divide: sel=1, a=0x06, b=0x03 -> result_o=0x02; a=0x01, b=0x02 -> 0x8E; a=0x00, b=0x57 -> 0x00, err_o=0.
- Divide by zero: sel=1, a=0x12, b=0x00 -> done_o in the cycle after T0, result_o=0x00, err_o=1, busy_o high 1 cycle.
- Operand stability: change op_a_i/op_b_i/op_select_i every cycle after the accept edge -> result computed from the latched values only; trigger during CALC/DONE is ignored.
- Exhaustive: every b in 1..255 with sel=0 -> result_o * b == 0x01 (checked with the reference model); trigger held high gives one op every 10 cycles.
